// File: rtl/axis_rr_arbiter_pkg.sv
// rtl/axis_rr_arbiter_pkg.sv - shared state type, default sizes and round-robin pick function for axis_rr_arbiter
package axis_rr_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int AXIS_ARB_N_SRC      = 4;
  localparam int AXIS_ARB_DATA_WIDTH = 8;
  localparam int AXIS_ARB_MAX_BURST  = 16;
  localparam int AXIS_ARB_PICK_W     = 16;

  // Returns {found, index}. Requests beyond N_SRC are zero-padded, so wrapping
  // modulo 16 visits the live sources in the same order as wrapping modulo N_SRC.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = AXIS_ARB_PICK_W - 1; i >= 0; i--) begin
      idx = ptr + 4'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// rtl/axis_rr_pick.sv - combinational round-robin priority encoder: first asserted request at or above ptr, wrapping
module axis_rr_pick
  import axis_rr_arbiter_pkg::*;
#(
  parameter int N_SRC = AXIS_ARB_N_SRC,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [15:0] req_pad;
  logic [3:0]  ptr_pad;
  logic [4:0]  pick;

  always_comb begin
    req_pad             = '0;
    req_pad[N_SRC-1:0]  = req;
    ptr_pad             = '0;
    ptr_pad[IDX_W-1:0]  = ptr;
    pick                = rr_pick(req_pad, ptr_pad);
  end

  assign found = pick[4];
  assign idx   = pick[IDX_W-1:0];

  wire unused_pick = ^pick;

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - round-robin AXI-Stream arbiter with bounded bursts; AXIS_RR_ARB_TLAST_EN switches to packet-atomic grants
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter  int N_SRC      = AXIS_ARB_N_SRC,
  parameter  int DATA_WIDTH = AXIS_ARB_DATA_WIDTH,
  parameter  int MAX_BURST  = AXIS_ARB_MAX_BURST,
  localparam int IDX_W      = $clog2(N_SRC)
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [N_SRC-1:0]            s_axis_tvalid,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
`ifdef AXIS_RR_ARB_TLAST_EN
  input  logic [N_SRC-1:0]            s_axis_tlast,
  output logic                        m_axis_tlast,
`endif
  output logic [N_SRC-1:0]            s_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  input  logic                        m_axis_tready,
  output logic                        grant_valid,
  output logic [IDX_W-1:0]            grant_id
);

  localparam int               CNT_W     = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(N_SRC - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             handshake;
  logic             release_grant;
  logic [DATA_WIDTH-1:0] src_data [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_src_data
    assign src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  axis_rr_pick #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_pick (
    .req   (s_axis_tvalid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    handshake     = 1'b0;
    release_grant = 1'b0;
`ifdef AXIS_RR_ARB_TLAST_EN
    m_axis_tlast  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // m_axis_tvalid depends only on the source, never on m_axis_tready
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tdata           = src_data[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        handshake              = m_axis_tvalid & m_axis_tready;
`ifdef AXIS_RR_ARB_TLAST_EN
        m_axis_tlast  = s_axis_tlast[grant_q];
        release_grant = handshake & s_axis_tlast[grant_q];
`else
        release_grant = (handshake && (beat_cnt_q == LAST_BEAT)) || !s_axis_tvalid[grant_q];
`endif
        if (release_grant) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
        end else if (handshake && (beat_cnt_q != LAST_BEAT)) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - self-checking bench for axis_rr_arbiter: instance 0 with MAX_BURST=16, instance 1 with MAX_BURST=4
module tb_axis_rr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int LOGSZ = 512;
  localparam int MEMSZ = 64;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]    s_tvalid [2];
  logic [N*DW-1:0] s_tdata  [2];
  logic [N-1:0]    s_tready [2];
  logic            m_tvalid [2];
  logic [DW-1:0]   m_tdata  [2];
  logic            m_tready [2];
  logic            gv       [2];
  logic [1:0]      gid      [2];
`ifdef AXIS_RR_ARB_TLAST_EN
  logic            m_tlast  [2];
`endif

  axis_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(16)) u_dut0 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_tvalid[0]),
    .s_axis_tdata  (s_tdata[0]),
`ifdef AXIS_RR_ARB_TLAST_EN
    .s_axis_tlast  ('0),
    .m_axis_tlast  (m_tlast[0]),
`endif
    .s_axis_tready (s_tready[0]),
    .m_axis_tvalid (m_tvalid[0]),
    .m_axis_tdata  (m_tdata[0]),
    .m_axis_tready (m_tready[0]),
    .grant_valid   (gv[0]),
    .grant_id      (gid[0])
  );

  axis_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut1 (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_tvalid[1]),
    .s_axis_tdata  (s_tdata[1]),
`ifdef AXIS_RR_ARB_TLAST_EN
    .s_axis_tlast  ('0),
    .m_axis_tlast  (m_tlast[1]),
`endif
    .s_axis_tready (s_tready[1]),
    .m_axis_tvalid (m_tvalid[1]),
    .m_axis_tdata  (m_tdata[1]),
    .m_axis_tready (m_tready[1]),
    .grant_valid   (gv[1]),
    .grant_id      (gid[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner (-1 = nobody), beats in current grant, search start
  int maxb  [2] = '{16, 4};
  int own   [2] = '{-1, -1};
  int ptr   [2] = '{0, 0};
  int beats [2] = '{0, 0};

  int         glog [2][LOGSZ];
  int         blog [2][LOGSZ];
  logic [7:0] rlog [2][LOGSZ];
  int         gn [2] = '{0, 0};
  int         bn [2] = '{0, 0};
  int         rn [2] = '{0, 0};
  int         rdy02_cnt = 0;

  logic [N-1:0] pop    [2] = '{'0, '0};
  logic         toggle [2] = '{1'b0, 1'b0};
  logic [7:0]   src_mem  [2][N][MEMSZ];
  int           src_len  [2][N];
  int           src_head [2][N];

  int seq2 [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp5 [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41, 8'h42, 8'h43,
                            8'h04, 8'h05, 8'h06, 8'h07, 8'h44, 8'h45, 8'h46, 8'h47,
                            8'h08, 8'h09, 8'h48, 8'h49};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    logic         ev;
    logic [N-1:0] er;
    for (int k = 0; k < 2; k++) begin
      if (!aresetn) begin
        own[k]   = -1;
        ptr[k]   = 0;
        beats[k] = 0;
      end
      ev = (own[k] >= 0) ? s_tvalid[k][own[k]] : 1'b0;
      er = '0;
      if (own[k] >= 0 && m_tready[k]) er[own[k]] = 1'b1;
      chk("m_axis_tvalid", m_tvalid[k], ev);
      chk("s_axis_tready", s_tready[k], er);
      chk("grant_valid", gv[k], own[k] >= 0);
      if (own[k] >= 0) chk("grant_id", gid[k], own[k]);
      if (ev) chk("m_axis_tdata", m_tdata[k], s_tdata[k][own[k]*DW +: DW]);
      pop[k] = s_tvalid[k] & s_tready[k];
      if (m_tvalid[k] && m_tready[k]) begin
        if (rn[k] < LOGSZ) rlog[k][rn[k]] = m_tdata[k];
        rn[k]++;
      end
    end
    if (s_tready[0][0] || s_tready[0][2]) rdy02_cnt++;
  end

  always @(posedge aclk) begin
    int   c, o;
    logic hs;
    for (int k = 0; k < 2; k++) begin
      if (!aresetn) begin
        own[k]   = -1;
        ptr[k]   = 0;
        beats[k] = 0;
      end else if (own[k] < 0) begin
        for (int j = 0; j < N; j++) begin
          c = (ptr[k] + j) % N;
          if (own[k] < 0 && s_tvalid[k][c]) own[k] = c;
        end
        if (own[k] >= 0) begin
          beats[k] = 0;
          if (gn[k] < LOGSZ) glog[k][gn[k]] = own[k];
          gn[k]++;
        end
      end else begin
        o  = own[k];
        hs = s_tvalid[k][o] && m_tready[k];
        if (hs) beats[k]++;
        if ((hs && beats[k] == maxb[k]) || !s_tvalid[k][o]) begin
          if (bn[k] < LOGSZ) blog[k][bn[k]] = beats[k];
          bn[k]++;
          ptr[k]   = (o + 1) % N;
          own[k]   = -1;
          beats[k] = 0;
        end
      end
    end
  end

  task automatic drive();
    logic v;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        v = src_head[k][i] < src_len[k][i];
        s_tvalid[k][i] = v;
        s_tdata[k][i*DW +: DW] = v ? src_mem[k][i][src_head[k][i]] : 8'h00;
      end
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) if (pop[k][i]) src_head[k][i]++;
      if (toggle[k]) m_tready[k] = ~m_tready[k];
    end
    drive();
  endtask

  task automatic load(input int k, input int s, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      if (src_len[k][s] < MEMSZ) begin
        src_mem[k][s][src_len[k][s]] = 8'(base + j);
        src_len[k][s]++;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      toggle[k]   = 1'b0;
      m_tready[k] = 1'b1;
      for (int i = 0; i < N; i++) begin
        src_len[k][i]  = 0;
        src_head[k][i] = 0;
      end
    end
    drive();
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic wait_rn(input int k, input int target, input int budget, input string name, output int cyc);
    cyc = 0;
    while (rn[k] < target && cyc < budget) begin
      step();
      cyc++;
    end
    chk({name, "_timeout"}, rn[k] >= target, 1);
  endtask

  task automatic wait_idle(input int k, input int budget, input string name);
    int c;
    bit busy;
    c    = 0;
    busy = 1'b1;
    while (busy && c < budget) begin
      busy = (own[k] >= 0);
      for (int i = 0; i < N; i++) if (src_head[k][i] < src_len[k][i]) busy = 1'b1;
      if (busy) begin
        step();
        c++;
      end
    end
    chk({name, "_timeout"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, g0, b0, r0, c0;
    for (int k = 0; k < 2; k++) begin
      m_tready[k] = 1'b1;
      s_tvalid[k] = '0;
      s_tdata[k]  = '0;
      for (int i = 0; i < N; i++) begin
        src_len[k][i]  = 0;
        src_head[k][i] = 0;
      end
    end
    aresetn = 1'b0;
    step();
    step();
    chk("reset_grant_valid", gv[0], 0);
    chk("reset_m_axis_tvalid", m_tvalid[0], 0);
    chk("reset_s_axis_tready", s_tready[0], 0);
    chk("reset_grant_id", gid[1], 0);
    aresetn = 1'b1;
    step();

    // single source, 40 beats -> bursts 16, 16, 8 with one-cycle bubbles
    g0 = gn[0]; b0 = bn[0]; r0 = rn[0];
    load(0, 0, 8'h00, 40);
    wait_rn(0, r0 + 40, 100, "t1_recv", cyc);
    chk("t1_cycles_to_last_beat", cyc, 43);
    wait_idle(0, 20, "t1_idle");
    chk("t1_grant_count", gn[0] - g0, 3);
    for (int j = 0; j < 3; j++) begin
      chk("t1_grant_id", glog[0][g0 + j], 0);
      chk("t1_burst_len", blog[0][b0 + j], (j == 2) ? 8 : 16);
    end
    for (int n = 0; n < 40; n++) chk("t1_data", rlog[0][r0 + n], n);

    // full contention from reset
    do_reset();
    g0 = gn[0]; b0 = bn[0]; r0 = rn[0];
    for (int s = 0; s < N; s++) load(0, s, s * 64, 40);
    wait_idle(0, 300, "t2_idle");
    chk("t2_total_beats", rn[0] - r0, 160);
    for (int j = 0; j < 5; j++) begin
      chk("t2_grant_id", glog[0][g0 + j], seq2[j]);
      chk("t2_burst_len", blog[0][b0 + j], 16);
      for (int n = 0; n < 16; n++)
        chk("t2_data", rlog[0][r0 + j*16 + n], seq2[j]*64 + ((j == 4) ? 16 : 0) + n);
    end

    // sources 1 and 3 only; pointer sits at 2 after the grant to 1
    do_reset();
    g0 = gn[0]; b0 = bn[0]; r0 = rn[0]; c0 = rdy02_cnt;
    load(0, 1, 8'h40, 3);
    wait_idle(0, 30, "t3a_idle");
    load(0, 1, 8'h50, 4);
    load(0, 3, 8'hC0, 4);
    wait_idle(0, 40, "t3b_idle");
    chk("t3_grant_count", gn[0] - g0, 3);
    chk("t3_grant0", glog[0][g0], 1);
    chk("t3_grant1", glog[0][g0 + 1], 3);
    chk("t3_grant2", glog[0][g0 + 2], 1);
    chk("t3_burst0", blog[0][b0], 3);
    chk("t3_burst1", blog[0][b0 + 1], 4);
    chk("t3_burst2", blog[0][b0 + 2], 4);
    chk("t3_tready_0_2_cycles", rdy02_cnt - c0, 0);
    chk("t3_first_after_ptr2", rlog[0][r0 + 3], 8'hC0);

    // source 2 goes idle after 5 beats, source 3 follows
    do_reset();
    g0 = gn[0]; b0 = bn[0]; r0 = rn[0];
    load(0, 2, 8'h80, 5);
    load(0, 3, 8'hC0, 6);
    wait_idle(0, 40, "t4_idle");
    chk("t4_grant0", glog[0][g0], 2);
    chk("t4_grant1", glog[0][g0 + 1], 3);
    chk("t4_burst0", blog[0][b0], 5);
    chk("t4_burst1", blog[0][b0 + 1], 6);
    for (int n = 0; n < 11; n++)
      chk("t4_data", rlog[0][r0 + n], (n < 5) ? 8'h80 + n : 8'hC0 + n - 5);

    // MAX_BURST=4 instance with m_axis_tready toggling every cycle
    do_reset();
    g0 = gn[1]; b0 = bn[1]; r0 = rn[1];
    toggle[1] = 1'b1;
    load(1, 0, 8'h00, 10);
    load(1, 1, 8'h40, 10);
    wait_idle(1, 100, "t5_idle");
    toggle[1]   = 1'b0;
    m_tready[1] = 1'b1;
    chk("t5_total_beats", rn[1] - r0, 20);
    chk("t5_grant_count", gn[1] - g0, 6);
    for (int j = 0; j < 6; j++) begin
      chk("t5_grant_id", glog[1][g0 + j], j % 2);
      chk("t5_burst_len", blog[1][b0 + j], (j >= 4) ? 2 : 4);
    end
    for (int n = 0; n < 20; n++) chk("t5_data", rlog[1][r0 + n], exp5[n]);

    // reset pulse in the middle of a burst from source 2
    do_reset();
    r0 = rn[0];
    load(0, 2, 8'h80, 20);
    wait_rn(0, r0 + 7, 40, "t6_recv7", cyc);
    load(0, 1, 8'h40, 4);
    load(0, 3, 8'hC0, 4);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_m_axis_tvalid", m_tvalid[0], 0);
    chk("t6_rst_grant_valid", gv[0], 0);
    chk("t6_rst_s_axis_tready", s_tready[0], 0);
    step();
    step();
    aresetn = 1'b1;
    g0 = gn[0];
    wait_idle(0, 200, "t6_idle");
    chk("t6_first_grant_after_reset", glog[0][g0], 1);
    chk("t6_first_beat_after_reset", rlog[0][r0 + 7], 8'h40);
    chk("t6_total_beats", rn[0] - r0, 28);
    chk("t6_resumed_src2", rlog[0][r0 + 11], 8'h87);

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
